// File: rtl/am2302_responder.sv
// rtl/am2302_responder.sv - AM2302/DHT22 sensor-side responder: start detect, preamble, 40-bit frame.
// Optional AM2302_FAULT_INJECT_EN adds fault_inj, which inverts the transmitted checksum.
module am2302_responder #(
  parameter int START_MIN = 29520,
  parameter int GO_DLY    = 1107,
  parameter int RESP_LOW  = 2952,
  parameter int RESP_HIGH = 2952,
  parameter int BIT_LOW   = 1845,
  parameter int BIT0_HIGH = 959,
  parameter int BIT1_HIGH = 2583
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sda_in,
  output logic        sda_oe,
  input  logic [15:0] hum_in,
  input  logic [15:0] temp_in,
  input  logic        load,
`ifdef AM2302_FAULT_INJECT_EN
  input  logic        fault_inj,
`endif
  output logic        busy,
  output logic        frame_done,
  output logic        start_err,
  output logic [7:0]  frame_cnt
);

  typedef enum logic [2:0] {IDLE, HLOW, GO, RLOW, RHIGH, BLOW, BHIGH, ELOW} state_t;

  localparam logic [15:0] START_MIN_C = 16'(START_MIN);
  localparam logic [15:0] GO_END      = 16'(GO_DLY - 1);
  localparam logic [15:0] RLOW_END    = 16'(RESP_LOW - 1);
  localparam logic [15:0] RHIGH_END   = 16'(RESP_HIGH - 1);
  localparam logic [15:0] BLOW_END    = 16'(BIT_LOW - 1);
  localparam logic [15:0] B0_END      = 16'(BIT0_HIGH - 1);
  localparam logic [15:0] B1_END      = 16'(BIT1_HIGH - 1);

  state_t      state;
  logic [15:0] cnt;
  logic [5:0]  idx;
  logic [39:0] frame;
  logic [15:0] hum_sh, temp_sh;
  logic        sda_m, sda_s;

  // Load in the same cycle as start qualification must reach the frame, so bypass the shadows.
  logic [15:0] hum_nx, temp_nx;
  logic [7:0]  chk, chk_tx;
  logic [15:0] bhigh_end;

  always_comb begin
    hum_nx    = load ? hum_in : hum_sh;
    temp_nx   = load ? temp_in : temp_sh;
    chk       = hum_nx[15:8] + hum_nx[7:0] + temp_nx[15:8] + temp_nx[7:0];
`ifdef AM2302_FAULT_INJECT_EN
    chk_tx    = fault_inj ? ~chk : chk;
`else
    chk_tx    = chk;
`endif
    bhigh_end = frame[39] ? B1_END : B0_END;
  end

  // Synchroniser idles high so reset release never looks like a host start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sda_m   <= 1'b1;
      sda_s   <= 1'b1;
      hum_sh  <= '0;
      temp_sh <= '0;
    end else begin
      sda_m <= sda_in;
      sda_s <= sda_m;
      if (load) begin
        hum_sh  <= hum_in;
        temp_sh <= temp_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      frame      <= '0;
      sda_oe     <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      start_err  <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      frame_done <= 1'b0;
      start_err  <= 1'b0;
      case (state)
        IDLE: begin
          sda_oe <= 1'b0;
          if (!sda_s) begin
            state <= HLOW;
            cnt   <= '0;
          end
        end
        HLOW: begin
          if (sda_s) begin
            if (cnt >= START_MIN_C) begin
              state <= GO;
              cnt   <= '0;
              idx   <= 6'd39;
              frame <= {hum_nx, temp_nx, chk_tx};
              busy  <= 1'b1;
            end else begin
              state     <= IDLE;
              start_err <= 1'b1;
            end
          end else if (cnt != 16'hFFFF) begin
            cnt <= cnt + 16'd1;
          end
        end
        GO: begin
          if (cnt == GO_END) begin
            state  <= RLOW;
            sda_oe <= 1'b1;
            cnt    <= '0;
          end else cnt <= cnt + 16'd1;
        end
        RLOW: begin
          if (cnt == RLOW_END) begin
            state  <= RHIGH;
            sda_oe <= 1'b0;
            cnt    <= '0;
          end else cnt <= cnt + 16'd1;
        end
        RHIGH: begin
          if (cnt == RHIGH_END) begin
            state  <= BLOW;
            sda_oe <= 1'b1;
            cnt    <= '0;
          end else cnt <= cnt + 16'd1;
        end
        BLOW: begin
          if (cnt == BLOW_END) begin
            state  <= BHIGH;
            sda_oe <= 1'b0;
            cnt    <= '0;
          end else cnt <= cnt + 16'd1;
        end
        BHIGH: begin
          if (cnt == bhigh_end) begin
            state  <= (idx == 6'd0) ? ELOW : BLOW;
            sda_oe <= 1'b1;
            cnt    <= '0;
            idx    <= idx - 6'd1;
            frame  <= {frame[38:0], 1'b0};
          end else cnt <= cnt + 16'd1;
        end
        ELOW: begin
          if (cnt == BLOW_END) begin
            state      <= IDLE;
            sda_oe     <= 1'b0;
            cnt        <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b1;
            frame_cnt  <= frame_cnt + 8'd1;
          end else cnt <= cnt + 16'd1;
        end
        default: begin
          state  <= IDLE;
          sda_oe <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_am2302_responder.sv
// tb/tb_am2302_responder.sv - self-checking bench for am2302_responder with scaled timing parameters.
module tb_am2302_responder;
  localparam int START_MIN = 10, GO_DLY = 2, RESP_LOW = 3, RESP_HIGH = 4;
  localparam int BIT_LOW = 2, BIT0_HIGH = 1, BIT1_HIGH = 3;
  localparam int TMO = 200;
  localparam int LAT = 3;

  logic clk = 0, rst_n = 0, sda_in = 1, load = 0;
  logic [15:0] hum_in = 0, temp_in = 0;
  logic sda_oe, busy, frame_done, start_err;
  logic [7:0] frame_cnt;
`ifdef AM2302_FAULT_INJECT_EN
  logic fault_inj = 0;
`endif

  int n_chk = 0, n_pass = 0;
  logic [15:0] ref_hum = 0, ref_temp = 0;
  logic [7:0]  exp_cnt = 0;
  int cap_go, cap_rlow, cap_rhigh, cap_elow;
  int cap_lo[40], cap_hi[40];
  logic cap_done, cap_busy_end, cap_busy_mid;
  logic [7:0] cap_cnt;

  am2302_responder #(
    .START_MIN(START_MIN), .GO_DLY(GO_DLY), .RESP_LOW(RESP_LOW), .RESP_HIGH(RESP_HIGH),
    .BIT_LOW(BIT_LOW), .BIT0_HIGH(BIT0_HIGH), .BIT1_HIGH(BIT1_HIGH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sda_in(sda_in), .sda_oe(sda_oe),
    .hum_in(hum_in), .temp_in(temp_in), .load(load),
`ifdef AM2302_FAULT_INJECT_EN
    .fault_inj(fault_inj),
`endif
    .busy(busy), .frame_done(frame_done), .start_err(start_err), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [39:0] ref_frame(input logic [15:0] h, input logic [15:0] t);
    int s;
    s = int'(h[15:8]) + int'(h[7:0]) + int'(t[15:8]) + int'(t[7:0]);
    return {h, t, 8'(s % 256)};
  endfunction

  function automatic logic [39:0] decoded();
    logic [39:0] v;
    for (int i = 0; i < 40; i++) v[39-i] = (cap_hi[i] * 2 > BIT0_HIGH + BIT1_HIGH);
    return v;
  endfunction

  task automatic do_load(input logic [15:0] h, input logic [15:0] t);
    @(negedge clk);
    hum_in = h; temp_in = t; load = 1;
    @(negedge clk);
    load = 0;
    ref_hum = h; ref_temp = t;
  endtask

  task automatic host_start(input int len);
    @(negedge clk);
    sda_in = 0;
    repeat (len) @(negedge clk);
    sda_in = 1;
  endtask

  task automatic measure(input logic lvl, output int len);
    len = 0;
    while (sda_oe === lvl && len < TMO) begin
      len++;
      @(negedge clk);
    end
  endtask

  task automatic capture();
    int len;
    len = 0;
    while (sda_oe === 1'b0 && len < TMO) begin
      @(negedge clk);
      len++;
    end
    cap_go = len;
    cap_busy_mid = busy;
    measure(1'b1, cap_rlow);
    measure(1'b0, cap_rhigh);
    for (int i = 0; i < 40; i++) begin
      measure(1'b1, cap_lo[i]);
      measure(1'b0, cap_hi[i]);
    end
    measure(1'b1, cap_elow);
    cap_done = frame_done; cap_busy_end = busy; cap_cnt = frame_cnt;
  endtask

  // Full-frame check against the reference: preamble, every bit phase, payload, end pulse.
  task automatic check_frame(input string nm, input logic [39:0] exp);
    int bad_lo, bad_hi;
    bad_lo = 0; bad_hi = 0;
    for (int i = 0; i < 40; i++) begin
      if (cap_lo[i] != BIT_LOW) bad_lo++;
      if (cap_hi[i] != (exp[39-i] ? BIT1_HIGH : BIT0_HIGH)) bad_hi++;
    end
    exp_cnt = exp_cnt + 8'd1;
    n_chk++; if (cap_go !== GO_DLY + LAT) $display("FAIL %s go_len: got %0d want %0d", nm, cap_go, GO_DLY + LAT); else n_pass++;
    n_chk++; if (cap_rlow !== RESP_LOW) $display("FAIL %s resp_low: got %0d want %0d", nm, cap_rlow, RESP_LOW); else n_pass++;
    n_chk++; if (cap_rhigh !== RESP_HIGH) $display("FAIL %s resp_high: got %0d want %0d", nm, cap_rhigh, RESP_HIGH); else n_pass++;
    n_chk++; if (decoded() !== exp) $display("FAIL %s data: got %h want %h", nm, decoded(), exp); else n_pass++;
    n_chk++; if (bad_lo != 0) $display("FAIL %s bit_low: got %0d bad phases want 0", nm, bad_lo); else n_pass++;
    n_chk++; if (bad_hi != 0) $display("FAIL %s bit_high: got %0d bad phases want 0", nm, bad_hi); else n_pass++;
    n_chk++; if (cap_elow !== BIT_LOW) $display("FAIL %s end_low: got %0d want %0d", nm, cap_elow, BIT_LOW); else n_pass++;
    n_chk++; if ({cap_busy_mid, cap_busy_end, cap_done} !== 3'b101) $display("FAIL %s busy/done: got %b want 101", nm, {cap_busy_mid, cap_busy_end, cap_done}); else n_pass++;
    n_chk++; if (cap_cnt !== exp_cnt) $display("FAIL %s frame_cnt: got %0d want %0d", nm, cap_cnt, exp_cnt); else n_pass++;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_chk++; if ({sda_oe, busy, frame_done, start_err} !== 4'b0) $display("FAIL reset_in: got %b want 0000", {sda_oe, busy, frame_done, start_err}); else n_pass++;
    rst_n = 1;
    repeat (3) @(negedge clk);
    n_chk++; if ({sda_oe, busy, frame_done, start_err} !== 4'b0) $display("FAIL reset_out: got %b want 0000", {sda_oe, busy, frame_done, start_err}); else n_pass++;
    n_chk++; if (frame_cnt !== 8'd0) $display("FAIL reset_cnt: got %0d want 0", frame_cnt); else n_pass++;
  endtask

  task automatic test_basic();
    do_load(16'h028C, 16'h0115);
    host_start(15);
    capture();
    check_frame("basic", ref_frame(ref_hum, ref_temp));
    n_chk++; if (decoded() !== 40'h028C0115A4) $display("FAIL basic_const: got %h want 028c0115a4", decoded()); else n_pass++;
  endtask

  task automatic test_bit_timing();
    do_load(16'hFFFF, 16'hFFFF);
    host_start(15);
    capture();
    check_frame("ones", ref_frame(ref_hum, ref_temp));
    do_load(16'h0000, 16'h0000);
    host_start(15);
    capture();
    check_frame("zeros", ref_frame(ref_hum, ref_temp));
  endtask

  task automatic test_random();
    for (int k = 0; k < 4; k++) begin
      do_load(16'($urandom), 16'($urandom));
      host_start(START_MIN + 2 + int'($urandom_range(0, 20)));
      capture();
      check_frame("random", ref_frame(ref_hum, ref_temp));
    end
  endtask

  task automatic test_short_start();
    logic saw_err, saw_oe, saw_busy;
    saw_err = 0; saw_oe = 0; saw_busy = 0;
    host_start(5);
    repeat (12) begin
      @(negedge clk);
      saw_err |= start_err; saw_oe |= sda_oe; saw_busy |= busy;
    end
    n_chk++; if (saw_err !== 1'b1) $display("FAIL short_err: got %b want 1", saw_err); else n_pass++;
    n_chk++; if ({saw_oe, saw_busy} !== 2'b00) $display("FAIL short_quiet: got %b want 00", {saw_oe, saw_busy}); else n_pass++;
    host_start(15);
    capture();
    check_frame("after_short", ref_frame(ref_hum, ref_temp));
  endtask

  task automatic test_midframe_load();
    logic [39:0] cur;
    logic inj_ok;
    int rises;
    logic prev;
    do_load(16'($urandom), 16'($urandom));
    cur = ref_frame(ref_hum, ref_temp);
    inj_ok = 0;
    host_start(15);
    fork
      capture();
      begin
        rises = 0; prev = sda_oe;
        for (int n = 0; n < 4000 && !inj_ok; n++) begin
          @(negedge clk);
          if (sda_oe && !prev) rises++;
          prev = sda_oe;
          // 12th rising edge of sda_oe opens bit 10's low phase.
          if (rises == 12) begin
            hum_in = 16'h1234; temp_in = 16'h5678; load = 1; sda_in = 0;
            @(negedge clk);
            load = 0;
            @(negedge clk);
            sda_in = 1;
            inj_ok = 1;
          end
        end
      end
    join
    n_chk++; if (inj_ok !== 1'b1) $display("FAIL mid_inject: got %b want 1", inj_ok); else n_pass++;
    check_frame("mid_current", cur);
    ref_hum = 16'h1234; ref_temp = 16'h5678;
    host_start(15);
    capture();
    check_frame("mid_next", ref_frame(ref_hum, ref_temp));
    n_chk++; if (decoded() !== 40'h1234567814) $display("FAIL mid_const: got %h want 1234567814", decoded()); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int rises, n;
    logic prev;
    do_load(16'hA5C3, 16'h7E19);
    host_start(15);
    rises = 0; prev = 0; n = 0;
    while (rises < 2 && n < TMO) begin
      @(negedge clk);
      if (sda_oe && !prev) rises++;
      prev = sda_oe; n++;
    end
    n_chk++; if (sda_oe !== 1'b1) $display("FAIL rmid_in_blow: got %b want 1", sda_oe); else n_pass++;
    #2 rst_n = 0;
    #1;
    n_chk++; if ({sda_oe, busy, frame_done, start_err} !== 4'b0) $display("FAIL rmid_async: got %b want 0000", {sda_oe, busy, frame_done, start_err}); else n_pass++;
    n_chk++; if (frame_cnt !== 8'd0) $display("FAIL rmid_cnt: got %0d want 0", frame_cnt); else n_pass++;
    @(negedge clk);
    rst_n = 1;
    ref_hum = 0; ref_temp = 0; exp_cnt = 0;
    host_start(15);
    capture();
    check_frame("after_reset", ref_frame(ref_hum, ref_temp));
  endtask

  task automatic test_wrap();
    int timeouts, w;
    timeouts = 0;
    while (exp_cnt != 8'd0) begin
      host_start(12);
      w = 0;
      while (frame_done !== 1'b1 && w < 400) begin
        @(negedge clk);
        w++;
      end
      if (w >= 400) timeouts++;
      exp_cnt = exp_cnt + 8'd1;
      if (exp_cnt == 8'd255) begin
        n_chk++; if (frame_cnt !== 8'd255) $display("FAIL wrap_255: got %0d want 255", frame_cnt); else n_pass++;
      end
    end
    n_chk++; if (timeouts != 0) $display("FAIL wrap_timeout: got %0d want 0", timeouts); else n_pass++;
    n_chk++; if (frame_cnt !== 8'd0) $display("FAIL wrap_cnt: got %0d want 0", frame_cnt); else n_pass++;
  endtask

`ifdef AM2302_FAULT_INJECT_EN
  task automatic test_fault();
    logic [39:0] exp;
    do_load(16'h028C, 16'h0115);
    fault_inj = 1;
    host_start(15);
    capture();
    fault_inj = 0;
    exp = ref_frame(ref_hum, ref_temp);
    exp[7:0] = ~exp[7:0];
    check_frame("fault", exp);
    n_chk++; if (decoded() !== 40'h028C01155B) $display("FAIL fault_chk: got %h want 028c01155b", decoded()); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_bit_timing();
    test_random();
    test_short_start();
    test_midframe_load();
    test_reset_mid();
    test_wrap();
`ifdef AM2302_FAULT_INJECT_EN
    test_fault();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
